// File: rtl/ram_master_pkg.sv
// Shared types and default widths for the RAM burst master.
package ram_master_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 64;
  localparam int LEN_W      = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/ram_rd_buf.sv
// Single-entry read-data register: captures a RAM word on load, holds it until accepted.
module ram_rd_buf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);
  // A load in the same cycle as acceptance refills the entry, giving 1 beat/cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (load) begin
      rdata  <= din;
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/ram_burst_master.sv
// Burst master: turns host read/write bursts into single-cycle RAM accesses.
module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              done,
  output logic              m_cen,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout
);
  state_e             state, nxt;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   len, cnt;
  logic               issue, last;

  // A beat goes to the RAM when the write stream has data or the read buffer has room.
  always_comb begin
    issue = 1'b0;
    case (state)
      WRITE:   issue = wvalid;
      READ:    issue = !rvalid || rready;
      default: issue = 1'b0;
    endcase
  end
  assign last = (cnt == len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      len  <= '0;
      cnt  <= '0;
    end else if (state == IDLE && req_valid) begin
      addr <= req_addr;
      len  <= req_len;
      cnt  <= '0;
    end else if (issue) begin
      addr <= addr + 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = req_wr ? WRITE : READ;
      WRITE:   if (issue && last) nxt = DONE;
      READ:    if (issue && last) nxt = DRAIN;
      DRAIN:   if (rvalid && rready) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    wready    = (state == WRITE);
    done      = (state == DONE);
    m_cen     = issue;
    m_wen     = issue && (state == WRITE);
    m_addr    = issue ? addr : '0;
    m_din     = (issue && state == WRITE) ? wdata : '0;
  end

  ram_rd_buf #(.DATA_W(DATA_W)) u_rd_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (issue && state == READ),
    .din    (m_dout),
    .rready (rready),
    .rdata  (rdata),
    .rvalid (rvalid)
  );
endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 64, RAM word width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  in  1  host burst request valid.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid & req_ready.
REQ-007 SHALL have port req_wr  in  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port req_addr  in  ADDR_W  burst start address.
REQ-009 SHALL have port req_len  in  4  beats minus one (0 -> 1 beat, 15 -> 16 beats).
REQ-010 SHALL have ports wdata  in  DATA_W, wvalid  in  1, wready  out  1: write-data stream.
REQ-011 SHALL have ports rdata  out  DATA_W, rvalid  out  1, rready  in  1: read-data stream.
REQ-012 SHALL have port done  out  1  one-cycle pulse at burst completion.
REQ-013 SHALL have ports m_cen, m_wen  out  1 each: RAM chip enable and write enable, active-high.
REQ-014 SHALL have ports m_addr  out  ADDR_W, m_din  out  DATA_W, m_dout  in  DATA_W: RAM address and data.

Function
REQ-015 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-016 IDLE: req_ready=1; on req_valid SHALL latch addr, len, wr and go to WRITE (req_wr=1) or READ (req_wr=0); req_valid SHALL be ignored in all other states.
REQ-017 WRITE: wready=1; each cycle with wvalid=1 SHALL drive m_cen=1, m_wen=1, m_addr=current address, m_din=wdata combinationally, and count one beat.
REQ-018 WRITE with wvalid=0 SHALL drive m_cen=0 (bubble): no RAM write, no address advance.
REQ-019 After the last write beat SHALL go to DONE.
REQ-020 RAM port contract: with m_cen=1, m_wen=0, m_dout is valid in the same cycle as m_addr; the master samples m_dout on the closing clock edge.
REQ-021 READ: SHALL issue a read (m_cen=1, m_wen=0) only when !rvalid | rready; the read word SHALL be registered into rdata, with rvalid=1 on the next cycle.
REQ-022 rvalid/rdata SHALL hold stable until rvalid & rready; a new read SHALL be issued in the same cycle as that acceptance (1 beat/cycle with rready=1).
REQ-023 After issuing the last read SHALL go to DRAIN; leave DRAIN for DONE on acceptance of the final rdata.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; req_ready=0 in DONE.
REQ-025 Address SHALL increment by 1 per issued beat, modulo 2^ADDR_W (255 -> 0 wraps, no error).
REQ-026 Outside an issuing cycle m_cen=0, m_wen=0, m_addr=0, m_din=0.
REQ-027 Latency: first RAM access no earlier than the cycle after request acceptance; first rvalid exactly 1 cycle after the first read issue.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, beat counter 0, rvalid=0, rdata=0, done=0, wready=0, m_cen/m_wen/m_addr/m_din=0; req_ready=1 after release.
REQ-029 Reset mid-burst SHALL abort the burst with no resume and no done pulse; RAM contents already written stay as written.

Structure
REQ-030 Package ram_master_pkg SHALL hold the state enum, ADDR_W/DATA_W/LEN_W defaults.
REQ-031 The single-entry read-data register (rdata/rvalid hold logic) SHALL be sub-module ram_rd_buf; the RAM itself is instantiated only in the bench.

Verification
REQ-032 Write addr 10, len 2, data 64'h12aabbcc, 64'h2ccc, 64'h1234, wvalid=1 -> RAM[10..12] written on 3 consecutive cycles, done pulse 1 cycle after last beat.
REQ-033 Read addr 10, len 2, rready=1 -> rdata 64'h12aabbcc, 64'h2ccc, 64'h1234 on 3 consecutive cycles, then done.
REQ-034 Write addr 254, len 2 -> m_addr 254, 255, 0; read-back from 254 returns same 3 words.
REQ-035 Read len 3 with rready toggling 1,0,0,1,... -> rdata held stable while rready=0, m_cen=0 while buffer full, no word lost or duplicated.
REQ-036 Write len 3 with wvalid gaps -> m_cen=0 during gaps, addresses contiguous, exactly 4 RAM writes.
REQ-037 reset_n low during beat 2 of a write at addr 153 -> outputs 0 asynchronously, no done, next request accepted normally from IDLE.
